// File: rtl/ark_pkg.sv
// Shared definitions for the word-serial AddRoundKey stage: FSM state
// encoding, the default AES block width, and the word-slice index helper.
package ark_pkg;

    // Control states: waiting for a key, collecting words, presenting a block
    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2
    } ark_state_t;

    localparam int AES_BLOCK_W = 128;

    // MSB index of word slice k; word 0 occupies the most significant bits
    function automatic int key_slice_msb(input int k, input int word_w, input int block_w);
        return block_w - 1 - k * word_w;
    endfunction

endpackage

// File: rtl/round_key_xor_serial.sv
// round_key_xor_serial: collects one BLOCK_W-bit block from a WORD_W-bit
// stream, XORs each word with the matching slice of a latched round key and
// presents the whitened block on a valid/ready output.
// Optional feature macro: ARK_BYPASS_EN adds a per-block `bypass` input that
// stores words without the key XOR.
module round_key_xor_serial
    import ark_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef ARK_BYPASS_EN
    input  logic               bypass,
`endif
    input  logic [BLOCK_W-1:0] key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    ark_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BLOCK_W-1:0] key_reg;
    logic [BLOCK_W-1:0] acc_reg;
    logic [BLOCK_W-1:0] acc_next;
    logic [BLOCK_W-1:0] key_src;
    logic [WORD_W-1:0]  key_words [NWORDS];
    logic [WORD_W-1:0]  word_x;
    logic               key_take;
    logic               word_take;
    logic               first_word;

    // Handshake flags are decoded from state/cnt only, never from valid inputs
    assign first_word = (cnt_reg == '0);
    assign key_ready  = (state_reg == NOKEY) || ((state_reg == LOAD) && first_word);
    assign in_ready   = (state_reg == LOAD);
    assign out_valid  = (state_reg == HOLD);
    assign out_data   = acc_reg;

    assign key_take  = key_valid && key_ready;
    assign word_take = in_valid && in_ready;

    // A key arriving together with word 0 must whiten that word, so the
    // incoming key bypasses the register for the XOR
    assign key_src = (state_reg == LOAD && key_take) ? key_in : key_reg;

    // Split the active key into per-word slices
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_key_words
            assign key_words[gi] = key_src[key_slice_msb(gi, WORD_W, BLOCK_W) -: WORD_W];
        end
    endgenerate

`ifdef ARK_BYPASS_EN
    logic bypass_reg;
    logic bypass_eff;

    // Word 0 uses the live bypass input; later words use the latched copy
    assign bypass_eff = first_word ? bypass : bypass_reg;
    assign word_x     = bypass_eff ? in_data : (in_data ^ key_words[cnt_reg]);

    // Latch the bypass choice together with word 0 of each block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_reg <= 1'b0;
        end else if (word_take && first_word) begin
            bypass_reg <= bypass;
        end
    end
`else
    assign word_x = in_data ^ key_words[cnt_reg];
`endif

    // Merge the current whitened word into its slot of the accumulator
    always_comb begin
        acc_next = acc_reg;
        if (word_take) begin
            acc_next[key_slice_msb(int'(cnt_reg), WORD_W, BLOCK_W) -: WORD_W] = word_x;
        end
    end

    // Control FSM with word counter, key register and block accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= NOKEY;
            cnt_reg   <= '0;
            key_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            case (state_reg)
                NOKEY: begin
                    if (key_valid) begin
                        key_reg   <= key_in;
                        cnt_reg   <= '0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (key_take) begin
                        key_reg <= key_in;
                    end
                    if (word_take) begin
                        acc_reg <= acc_next;
                        if (cnt_reg == LAST_CNT) begin
                            cnt_reg   <= '0;
                            state_reg <= HOLD;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        cnt_reg   <= '0;
                        state_reg <= LOAD;
                    end
                end
                default: begin
                    state_reg <= NOKEY;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_xor_serial.sv
// Directed bench for round_key_xor_serial: byte-serial instance plus 32-bit
// and 128-bit word instances, all checked against hand-computed vectors.
module tb_round_key_xor_serial;

    localparam logic [127:0] KEY1  = 128'hcc96ed1674eaaa031e863f24b2a8316a;
    localparam logic [127:0] KEY2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] TEXT  = 128'h9faf634b37ec39fb518c04b137fa66d7;
    localparam logic [127:0] RES1  = 128'h53398e5d430693f84f0a3b95855257bd;
    localparam logic [127:0] RES2  = 128'h9fbe417873b95f8cd915ae0afb278828;

    logic         clk = 1'b0;
    logic         rst_n;
    int           checks = 0;
    int           failures = 0;

    // Byte-serial instance
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef ARK_BYPASS_EN
    logic         bypass;
`endif

    // Wide-word instances share key bus and reset
    logic         kv_w;
    logic         kr32, kr128;
    logic [31:0]  d32;
    logic [127:0] d128;
    logic         v32, v128;
    logic         ir32, ir128;
    logic [127:0] o32, o128;
    logic         ov32, ov128;

    always #5 clk = ~clk;

    round_key_xor_serial #(.WORD_W(8), .BLOCK_W(128)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
`ifdef ARK_BYPASS_EN
        .bypass(bypass),
`endif
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    round_key_xor_serial #(.WORD_W(32), .BLOCK_W(128)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
`ifdef ARK_BYPASS_EN
        .bypass(1'b0),
`endif
        .key_in(KEY1), .key_valid(kv_w), .key_ready(kr32),
        .in_data(d32), .in_valid(v32), .in_ready(ir32),
        .out_data(o32), .out_valid(ov32), .out_ready(1'b0)
    );

    round_key_xor_serial #(.WORD_W(128), .BLOCK_W(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n),
`ifdef ARK_BYPASS_EN
        .bypass(1'b0),
`endif
        .key_in(KEY1), .key_valid(kv_w), .key_ready(kr128),
        .in_data(d128), .in_valid(v128), .in_ready(ir128),
        .out_data(o128), .out_valid(ov128), .out_ready(1'b0)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one 16-byte block; optionally present a new key with byte 0
    task automatic send_block(input logic [127:0] text, input logic with_key,
                              input logic [127:0] k, input logic bp);
        for (int i = 0; i < 16; i++) begin
            in_data  = text[127 - 8*i -: 8];
            in_valid = 1'b1;
`ifdef ARK_BYPASS_EN
            bypass   = (i == 0) ? bp : 1'b0;
`endif
            if (i == 0 && with_key) begin
                key_in    = k;
                key_valid = 1'b1;
            end
            if (i == 0) check("word0_in_ready", {127'd0, in_ready}, 128'd1);
            if (i == 1) check("midblock_key_ready", {127'd0, key_ready}, 128'd0);
            step();
            key_valid = 1'b0;
            if (i == 14) check("out_valid_before_last", {127'd0, out_valid}, 128'd0);
        end
        in_valid = 1'b0;
        $display("block sent text=%h with_key=%0d bp=%0d -> out_valid=%0d out_data=%h",
                 text, with_key, bp, out_valid, out_data);
    endtask

    task automatic release_block();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; key_in = '0; key_valid = 1'b0; in_data = '0; in_valid = 1'b0;
        out_ready = 1'b0; kv_w = 1'b0; d32 = '0; d128 = '0; v32 = 1'b0; v128 = 1'b0;
`ifdef ARK_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (2) step();
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out_data", out_data, 128'd0);
        check("reset_in_ready", {127'd0, in_ready}, 128'd0);
        check("reset_key_ready", {127'd0, key_ready}, 128'd1);
        rst_n = 1'b1;
        step();

        // Key load, then the reference block
        key_in = KEY1; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        check("load_in_ready", {127'd0, in_ready}, 128'd1);
        check("load_key_ready", {127'd0, key_ready}, 128'd1);
        send_block(TEXT, 1'b0, '0, 1'b0);
        check("blk1_out_valid", {127'd0, out_valid}, 128'd1);
        check("blk1_out_data", out_data, RES1);

        // Backpressure: extra words offered must not be consumed
        in_valid = 1'b1; in_data = 8'haa;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_out_data", out_data, RES1);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
        end
        check("hold_key_ready", {127'd0, key_ready}, 128'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("release_out_valid", {127'd0, out_valid}, 128'd0);
        check("release_in_ready", {127'd0, in_ready}, 128'd1);

        // Zero text, key unchanged, out_ready held high
        send_block(128'd0, 1'b0, '0, 1'b0);
        check("blk2_out_valid", {127'd0, out_valid}, 128'd1);
        check("blk2_out_data", out_data, KEY1);
        step();
        check("blk2_hold_one_cycle", {127'd0, out_valid}, 128'd0);
        check("blk2_next_in_ready", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b0;

        // New key presented together with word 0
        send_block(TEXT, 1'b1, KEY2, 1'b0);
        check("blk3_out_data", out_data, RES2);
        release_block();

        // Reset pulse after 7 bytes
        for (int i = 0; i < 7; i++) begin
            in_data = TEXT[127 - 8*i -: 8]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        check("midrst_key_ready", {127'd0, key_ready}, 128'd1);
        check("midrst_out_data", out_data, 128'd0);
        step();
        rst_n = 1'b1;
        step();
        check("postrst_in_ready", {127'd0, in_ready}, 128'd0);
        key_in = KEY1; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        send_block(TEXT, 1'b0, '0, 1'b0);
        check("postrst_out_data", out_data, RES1);
        release_block();

`ifdef ARK_BYPASS_EN
        send_block(TEXT, 1'b0, '0, 1'b1);
        check("bypass_out_data", out_data, TEXT);
        release_block();
        send_block(TEXT, 1'b0, '0, 1'b0);
        check("nobypass_out_data", out_data, RES1);
        release_block();
`endif

        // 32-bit and 128-bit word instances on the same vector
        kv_w = 1'b1;
        step();
        kv_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d32 = TEXT[127 - 32*i -: 32]; v32 = 1'b1;
            if (i == 0) begin
                d128 = TEXT; v128 = 1'b1;
            end
            step();
            v128 = 1'b0;
            if (i == 0) begin
                check("w128_out_valid", {127'd0, ov128}, 128'd1);
                check("w128_out_data", o128, RES1);
                $display("w128 block -> out_valid=%0d out_data=%h", ov128, o128);
            end
            if (i < 3) check("w32_early_valid", {127'd0, ov32}, 128'd0);
        end
        v32 = 1'b0;
        check("w32_out_valid", {127'd0, ov32}, 128'd1);
        check("w32_out_data", o32, RES1);
        $display("w32 block -> out_valid=%0d out_data=%h", ov32, o32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
